// File: rtl/baudrate_generator_frac_if.sv
// Configuration and tick bundle between the UART config registers, the baud
// generator and the TX/RX shift engines.
//   transaction_en  : high for the whole duration of a transaction
//   mode_rx         : 0 = TX alignment, 1 = RX mid-bit alignment
//   div_int         : cycles per sample tick, integer part
//   div_frac        : cycles per sample tick, fraction (div_frac / 2^FRAC_W)
//   sample_tick     : one-cycle pulse per oversample period
//   baudrate_clk_en : one-cycle pulse per bit
//   cfg_err         : divisor too small while a transaction is requested
interface baudrate_generator_frac_if #(
   parameter int unsigned DIV_INT_W = 16,
   parameter int unsigned FRAC_W    = 4
);
   logic                 transaction_en;
   logic                 mode_rx;
   logic [DIV_INT_W-1:0] div_int;
   logic [FRAC_W-1:0]    div_frac;
   logic                 sample_tick;
   logic                 baudrate_clk_en;
   logic                 cfg_err;

   modport master (
      output transaction_en, mode_rx, div_int, div_frac,
      input  sample_tick, baudrate_clk_en, cfg_err
   );

   modport slave (
      input  transaction_en, mode_rx, div_int, div_frac,
      output sample_tick, baudrate_clk_en, cfg_err
   );
endinterface

// File: rtl/baudrate_generator_frac.sv
// UART baud tick generator with run-time integer + fractional divisor.
// Produces an oversampling tick and a bit tick, with TX (tick on start) or
// RX (first bit tick at mid-bit) alignment.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of baudrate_generator_frac_if (config in, ticks out)
module baudrate_generator_frac #(
   parameter int unsigned DIV_INT_W = 16,
   parameter int unsigned FRAC_W    = 4,
   parameter int unsigned OVS       = 16,
   parameter int unsigned OVS_W     = $clog2(OVS)
) (
   input  logic                      clk,
   input  logic                      rst,
   baudrate_generator_frac_if.slave  bus
);
   // One extra bit so div_int at full scale plus a fractional carry fits
   localparam int unsigned CNT_W = DIV_INT_W + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [FRAC_W-1:0]    acc, acc_n;
   logic [OVS_W-1:0]     os_cnt, os_n;
   logic [DIV_INT_W-1:0] sh_div, sh_div_n;
   logic [FRAC_W-1:0]    sh_frac, sh_frac_n;
   logic                 tick_q, tick_n;
   logic                 bclk_q, bclk_n;
   logic                 err_q, err_n;

   logic [DIV_INT_W-1:0] div_sel_c;
   logic [FRAC_W-1:0]    frac_sel_c;
   logic [FRAC_W:0]      sum_c;
   logic [CNT_W-1:0]     period_m1_c;
   logic [OVS_W-1:0]     os_inc_c;
   logic                 div_ok_c;

   // In IDLE the divisor is taken live (it is what the shadow latches this
   // edge); in RUN the frozen shadow copy is used.  mode_rx only matters at
   // the start edge, so it needs no shadow of its own.
   always_comb begin
      div_sel_c   = (state == IDLE) ? bus.div_int  : sh_div;
      frac_sel_c  = (state == IDLE) ? bus.div_frac : sh_frac;
      sum_c       = {1'b0, acc} + {1'b0, frac_sel_c};
      period_m1_c = CNT_W'(div_sel_c) + CNT_W'(sum_c[FRAC_W]) - CNT_W'(1);
      os_inc_c    = os_cnt + OVS_W'(1);
      div_ok_c    = (div_sel_c >= DIV_INT_W'(2));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      acc_n     = acc;
      os_n      = os_cnt;
      sh_div_n  = sh_div;
      sh_frac_n = sh_frac;
      tick_n    = 1'b0;
      bclk_n    = 1'b0;
      err_n     = 1'b0;

      case (state)
         IDLE: begin
            sh_div_n  = bus.div_int;
            sh_frac_n = bus.div_frac;
            cnt_n     = '0;
            acc_n     = '0;
            os_n      = '0;
            if (bus.transaction_en) begin
               if (!div_ok_c) begin
                  err_n = 1'b1;
               end else begin
                  state_n = RUN;
                  if (bus.mode_rx) begin
                     // First period starts now; offset os_cnt by half a bit
                     cnt_n = period_m1_c;
                     acc_n = sum_c[FRAC_W-1:0];
                     os_n  = OVS_W'(OVS / 2);
                  end else begin
                     // Counter at 0 next cycle acts as sample tick 0
                     tick_n = 1'b1;
                     bclk_n = 1'b1;
                  end
               end
            end
         end

         RUN: begin
            if (!bus.transaction_en) begin
               state_n = IDLE;
               cnt_n   = '0;
               acc_n   = '0;
               os_n    = '0;
            end else if (cnt == '0) begin
               // Previous period ended; start the next one with its carry
               cnt_n = period_m1_c;
               acc_n = sum_c[FRAC_W-1:0];
            end else begin
               cnt_n = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  tick_n = 1'b1;
                  os_n   = os_inc_c;
                  bclk_n = (os_inc_c == '0);
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         os_cnt  <= '0;
         sh_div  <= '0;
         sh_frac <= '0;
         tick_q  <= 1'b0;
         bclk_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         acc     <= acc_n;
         os_cnt  <= os_n;
         sh_div  <= sh_div_n;
         sh_frac <= sh_frac_n;
         tick_q  <= tick_n;
         bclk_q  <= bclk_n;
         err_q   <= err_n;
      end
   end

   assign bus.sample_tick     = tick_q;
   assign bus.baudrate_clk_en = bclk_q;
   assign bus.cfg_err         = err_q;
endmodule

// File: tb/tb_baudrate_generator_frac.sv
// Bench for baudrate_generator_frac: table of transactions with per-cycle
// expected ticks from an arithmetic schedule, plus hand sequences for
// cfg_err and mid-run reset.
module tb_baudrate_generator_frac;
   localparam int unsigned DIV_INT_W = 16;
   localparam int unsigned FRAC_W    = 4;
   localparam int unsigned OVS       = 16;
   localparam int          MAXC      = 200;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   baudrate_generator_frac_if #(.DIV_INT_W(DIV_INT_W), .FRAC_W(FRAC_W)) bus ();

   baudrate_generator_frac #(
      .DIV_INT_W(DIV_INT_W),
      .FRAC_W   (FRAC_W),
      .OVS      (OVS)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic mode;
      int   div;
      int   frac;
      int   ncyc;
      int   chg_at;
      int   chg_div;
      int   t1;
      int   b1;
      int   b2;
   } vec_t;

   vec_t       vecs [9];
   logic [2:0] sb_q [$];
   logic       exp_tick [MAXC];
   logic       exp_bclk [MAXC];
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Push expected {tick,bclk,err}, advance one edge, pop and compare
   task automatic step(input string name, input logic t, input logic b, input logic e);
      logic [2:0] exp_v, act_v;
      sb_q.push_back({t, b, e});
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      act_v = {bus.sample_tick, bus.baudrate_clk_en, bus.cfg_err};
      check({name, " {tick,bclk,err}"}, int'(act_v), int'(exp_v));
   endtask

   // Tick schedule from the closed-form carry floor(k*f/2^F)-floor((k-1)*f/2^F)
   task automatic build(input logic mode, input int div, input int frac, input int ncyc);
      int t, c;
      for (int i = 0; i < MAXC; i++) begin
         exp_tick[i] = 1'b0;
         exp_bclk[i] = 1'b0;
      end
      if (!mode) begin
         t = 1;
         exp_tick[1] = 1'b1;
         exp_bclk[1] = 1'b1;
      end else begin
         t = 0;
      end
      for (int k = 1; k < 10000; k++) begin
         c = (k * frac) / (1 << FRAC_W) - ((k - 1) * frac) / (1 << FRAC_W);
         t = t + div + c;
         if (t > ncyc) break;
         exp_tick[t] = 1'b1;
         if (mode ? (k % int'(OVS) == int'(OVS) / 2) : (k % int'(OVS) == 0))
            exp_bclk[t] = 1'b1;
      end
   endtask

   task automatic run_txn(input int vi);
      vec_t v;
      int   first_t;
      int   bc [$];
      v       = vecs[vi];
      first_t = -1;
      build(v.mode, v.div, v.frac, v.ncyc);
      bus.mode_rx        = v.mode;
      bus.div_int        = DIV_INT_W'(v.div);
      bus.div_frac       = FRAC_W'(v.frac);
      bus.transaction_en = 1'b1;
      for (int n = 1; n <= v.ncyc; n++) begin
         if (v.chg_at != 0 && n == v.chg_at) begin
            bus.div_int  = DIV_INT_W'(v.chg_div);
            bus.mode_rx  = ~v.mode;
            bus.div_frac = FRAC_W'(v.frac + 5);
         end
         step($sformatf("v%0d cyc%0d", vi, n), exp_tick[n], exp_bclk[n], 1'b0);
         if (bus.sample_tick && first_t < 0) first_t = n;
         if (bus.baudrate_clk_en) bc.push_back(n);
      end
      check($sformatf("v%0d first_tick_cycle", vi), first_t, v.t1);
      check($sformatf("v%0d bclk1_cycle", vi), (bc.size() > 0) ? bc[0] : -1, v.b1);
      check($sformatf("v%0d bclk2_cycle", vi), (bc.size() > 1) ? bc[1] : -1, v.b2);
   endtask

   task automatic end_txn(input string name);
      bus.transaction_en = 1'b0;
      step(name, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      //          mode  div    frac ncyc chg chgdiv t1  b1  b2
      vecs[0] = '{1'b0, 3,     0,   100, 0,  0,     1,  1,  49};
      vecs[1] = '{1'b0, 3,     8,   120, 0,  0,     1,  1,  57};
      vecs[2] = '{1'b1, 3,     0,   80,  0,  0,     3,  24, 72};
      vecs[3] = '{1'b0, 3,     0,   60,  5,  10,    1,  1,  49};
      vecs[4] = '{1'b0, 10,    0,   25,  0,  0,     1,  1,  -1};
      vecs[5] = '{1'b1, 5,     4,   130, 0,  0,     5,  42, 126};
      vecs[6] = '{1'b0, 2,     0,   40,  0,  0,     1,  1,  33};
      vecs[7] = '{1'b0, 2,     15,  60,  0,  0,     1,  1,  48};
      vecs[8] = '{1'b0, 4,     0,   40,  0,  0,     1,  1,  -1};

      rst                = 1'b1;
      bus.transaction_en = 1'b0;
      bus.mode_rx        = 1'b0;
      bus.div_int        = DIV_INT_W'(3);
      bus.div_frac       = '0;
      step("reset", 1'b0, 1'b0, 1'b0);
      step("reset_hold", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step("idle", 1'b0, 1'b0, 1'b0);

      // Divisor below 2: error flag, no ticks, clears after enable drops
      bus.div_int        = DIV_INT_W'(1);
      bus.transaction_en = 1'b1;
      for (int i = 1; i <= 8; i++) step($sformatf("cfg_err div1 cyc%0d", i), 1'b0, 1'b0, 1'b1);
      bus.div_int = '0;
      step("cfg_err div0", 1'b0, 1'b0, 1'b1);
      end_txn("cfg_err_clear");

      // Back-to-back transactions separated by a single IDLE cycle
      for (int vi = 0; vi < 8; vi++) begin
         run_txn(vi);
         end_txn($sformatf("v%0d end", vi));
      end

      // Reset mid-run with enable held: restart as a fresh transaction
      run_txn(8);
      rst = 1'b1;
      step("rst_midrun", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      run_txn(8);
      end_txn("rst_restart end");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
